// File: rtl/filter_mode_ctrl.sv
// Filter mode controller: debounced KEY mode selection applied at frame start,
// plus an active-area pixel scanner. Define FILTER_MODE_CTRL_HEX_EN for the HEX display decode.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// VSYNC       | after a VS fall (or reset); waiting for VS to return high
// WAIT_ACTIVE | vertical back porch; waiting for the first BLANK_N-high cycle
// ACTIVE      | scanning lines; x/y track the active pixel
module filter_mode_ctrl #(
  parameter int WIDTH           = 640,
  parameter int HEIGHT          = 480,
  parameter int NUM_MODES       = 4,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       VGA_CLK,
  input  logic       reset,
  input  logic       iVGA_HS,
  input  logic       iVGA_VS,
  input  logic       iVGA_BLANK_N,
  input  logic [1:0] KEY,
  output logic [2:0] mode,
  output logic [2:0] mode_pending,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       pixel_valid,
  output logic       frame_start,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1
);

  localparam int              CW        = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]   DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]      MODE_LAST = 3'(NUM_MODES - 1);
  localparam logic [9:0]      X_LAST    = 10'(WIDTH - 1);
  localparam logic [8:0]      Y_LAST    = 9'(HEIGHT - 1);
  localparam logic [9:0]      Y_LIMIT   = 10'(HEIGHT);

  typedef enum logic [1:0] {
    VSYNC       = 2'd0,
    WAIT_ACTIVE = 2'd1,
    ACTIVE      = 2'd2
  } state_t;

  logic [1:0]         key_s1_q, key_s2_q;
  logic [1:0][CW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]         armed_q, armed_d;
  logic [1:0]         accept;

  logic               vs_q, blank_q;
  logic               vs_fall;
  logic               synced_q, synced_d;
  state_t             state_q, state_d;
  logic [2:0]         mode_q, mode_d;
  logic [2:0]         pend_q, pend_d;
  logic [9:0]         x_q, x_d;
  logic [8:0]         y_q, y_d;
  logic               fs_q;

  // Line boundaries come from BLANK_N alone, so HS carries no information here.
  logic unused_hs;
  assign unused_hs = iVGA_HS;

  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      key_s1_q <= 2'b11;
      key_s2_q <= 2'b11;
    end else begin
      key_s1_q <= KEY;
      key_s2_q <= key_s1_q;
    end
  end

  // armed: waiting for a stable low (press); disarmed: waiting for a stable high.
  always_comb begin
    db_cnt_d = db_cnt_q;
    armed_d  = armed_q;
    accept   = 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (armed_q[k] ^ key_s2_q[k]) begin
        if (db_cnt_q[k] == DB_LAST) begin
          db_cnt_d[k] = '0;
          armed_d[k]  = ~armed_q[k];
          accept[k]   = armed_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + 1'b1;
        end
      end else begin
        db_cnt_d[k] = '0;
      end
    end
  end

  always_comb begin
    pend_d = pend_q;
    case (accept)
      2'b01:   pend_d = (pend_q == MODE_LAST) ? 3'd0 : pend_q + 3'd1;
      2'b10:   pend_d = (pend_q == 3'd0) ? MODE_LAST : pend_q - 3'd1;
      default: pend_d = pend_q;
    endcase
  end

  // mode samples the pending value from before this cycle's key action.
  assign vs_fall  = vs_q & ~iVGA_VS;
  assign mode_d   = vs_fall ? pend_q : mode_q;
  assign synced_d = synced_q | vs_fall;

  always_comb begin
    state_d = state_q;
    case (state_q)
      VSYNC:       if (synced_q && iVGA_VS) state_d = WAIT_ACTIVE;
      WAIT_ACTIVE: if (iVGA_BLANK_N) state_d = ACTIVE;
      ACTIVE:      state_d = ACTIVE;
      default:     state_d = VSYNC;
    endcase
    if (vs_fall) state_d = VSYNC;
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (vs_fall) begin
      x_d = '0;
      y_d = '0;
    end else if (state_q == ACTIVE) begin
      if (blank_q && !iVGA_BLANK_N) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? y_q : y_q + 9'd1;
      end else if (blank_q && iVGA_BLANK_N) begin
        x_d = (x_q == X_LAST) ? x_q : x_q + 10'd1;
      end
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      db_cnt_q <= '0;
      armed_q  <= 2'b00;
      vs_q     <= 1'b0;
      blank_q  <= 1'b0;
      synced_q <= 1'b0;
      state_q  <= VSYNC;
      mode_q   <= 3'd0;
      pend_q   <= 3'd0;
      x_q      <= '0;
      y_q      <= '0;
      fs_q     <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      armed_q  <= armed_d;
      vs_q     <= iVGA_VS;
      blank_q  <= iVGA_BLANK_N;
      synced_q <= synced_d;
      state_q  <= state_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      x_q      <= x_d;
      y_q      <= y_d;
      fs_q     <= vs_fall;
    end
  end

  assign mode         = mode_q;
  assign mode_pending = pend_q;
  assign x            = x_q;
  assign y            = y_q;
  assign frame_start  = fs_q;
  assign pixel_valid  = (state_q == ACTIVE) && blank_q && ({1'b0, y_q} < Y_LIMIT);

`ifdef FILTER_MODE_CTRL_HEX_EN
  function automatic logic [6:0] seg7(input logic [2:0] d);
    logic [6:0] s;
    case (d)
      3'd0:    s = 7'h40;
      3'd1:    s = 7'h79;
      3'd2:    s = 7'h24;
      3'd3:    s = 7'h30;
      3'd4:    s = 7'h19;
      3'd5:    s = 7'h12;
      3'd6:    s = 7'h02;
      default: s = 7'h78;
    endcase
    return s;
  endfunction

  logic [6:0] hex0_q, hex1_q;

  // Decoded from next-state values so the display changes with mode, not a cycle later.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      hex0_q <= 7'h7F;
      hex1_q <= 7'h7F;
    end else begin
      hex0_q <= seg7(mode_d);
      hex1_q <= (pend_d != mode_d) ? 7'h0C : 7'h7F;
    end
  end

  assign HEX0 = hex0_q;
  assign HEX1 = hex1_q;
`else
  assign HEX0 = 7'h7F;
  assign HEX1 = 7'h7F;
`endif

endmodule

// File: tb/tb_filter_mode_ctrl.sv
// Bench for filter_mode_ctrl: directed key/frame scenarios plus randomized key
// activity checked against a modulo-arithmetic mode model.
module tb_filter_mode_ctrl;

  localparam int D  = 4;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int NM = 4;

  logic       VGA_CLK = 1'b0;
  logic       reset;
  logic       hs, vs, blank;
  logic [1:0] KEY;
  logic [2:0] mode, mode_pending;
  logic [9:0] x;
  logic [8:0] y;
  logic       pixel_valid, frame_start;
  logic [6:0] HEX0, HEX1;

  int checks = 0;
  int errors = 0;
  int exp_pending = 0;
  int exp_mode = 0;

  filter_mode_ctrl #(.WIDTH(W), .HEIGHT(H), .NUM_MODES(NM), .DEBOUNCE_CYCLES(D)) dut (
    .VGA_CLK(VGA_CLK), .reset(reset), .iVGA_HS(hs), .iVGA_VS(vs), .iVGA_BLANK_N(blank),
    .KEY(KEY), .mode(mode), .mode_pending(mode_pending), .x(x), .y(y),
    .pixel_valid(pixel_valid), .frame_start(frame_start), .HEX0(HEX0), .HEX1(HEX1)
  );

  always #20 VGA_CLK = ~VGA_CLK;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int next_mode(input int m, input int up);
    return up ? (m + 1) % NM : (m + NM - 1) % NM;
  endfunction

  function automatic logic [6:0] exp_hex0();
`ifdef FILTER_MODE_CTRL_HEX_EN
    logic [6:0] seg [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
    return seg[exp_mode];
`else
    return 7'h7F;
`endif
  endfunction

  function automatic logic [6:0] exp_hex1();
`ifdef FILTER_MODE_CTRL_HEX_EN
    return (exp_pending != exp_mode) ? 7'h0C : 7'h7F;
`else
    return 7'h7F;
`endif
  endfunction

  task automatic step();
    @(posedge VGA_CLK);
    #1;
  endtask

  // Hold one key low, release it, then leave it high long enough to re-arm.
  task automatic press(input int k, input int hold);
    KEY[k] = 1'b0;
    repeat (hold) step();
    KEY[k] = 1'b1;
    repeat (D + 4) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; vs = 1'b1; blank = 1'b0; hs = 1'b1; KEY = 2'b11;
    step(); step();
    checks++;
    if ({mode, mode_pending, x, y, pixel_valid, frame_start} !== 27'd0)
      begin errors++; $display("FAIL reset_outputs: got mode=%0d pend=%0d x=%0d y=%0d pv=%b fs=%b, expected all 0",
                               mode, mode_pending, x, y, pixel_valid, frame_start); end
    checks++;
    if (HEX0 !== 7'h7F) begin errors++; $display("FAIL reset_hex0: got %h expected 7f", HEX0); end
    checks++;
    if (HEX1 !== 7'h7F) begin errors++; $display("FAIL reset_hex1: got %h expected 7f", HEX1); end
    reset = 1'b0;
    repeat (D + 4) step();
    checks++;
    if ({mode, mode_pending, pixel_valid} !== 7'd0)
      begin errors++; $display("FAIL post_reset_idle: got mode=%0d pend=%0d pv=%b expected 0", mode, mode_pending, pixel_valid); end
  endtask

  // VS falling edge: expect a one-cycle frame_start with mode taking the pending value.
  task automatic test_frame_start();
    exp_mode = exp_pending;
    vs = 1'b0;
    step();
    checks++;
    if ({frame_start, mode, x, y, pixel_valid} !== {1'b1, 3'(exp_mode), 10'd0, 9'd0, 1'b0})
      begin errors++; $display("FAIL frame_start_edge: got fs=%b mode=%0d x=%0d y=%0d pv=%b expected fs=1 mode=%0d x=0 y=0 pv=0",
                               frame_start, mode, x, y, pixel_valid, exp_mode); end
    step();
    checks++;
    if (frame_start !== 1'b0) begin errors++; $display("FAIL frame_start_width: got fs=%b expected 0", frame_start); end
    vs = 1'b1;
    step(); step();
  endtask

  task automatic test_clean_press();
    KEY[0] = 1'b0;
    repeat (10) step();
    KEY[0] = 1'b1;
    exp_pending = next_mode(exp_pending, 1);
    repeat (D + 4) step();
    checks++;
    if (mode_pending !== 3'd1) begin errors++; $display("FAIL clean_press_pending: got %0d expected 1", mode_pending); end
    checks++;
    if (mode !== 3'd0) begin errors++; $display("FAIL clean_press_mode_held: got %0d expected 0", mode); end
    test_frame_start();
    checks++;
    if (mode !== 3'd1) begin errors++; $display("FAIL clean_press_mode_applied: got %0d expected 1", mode); end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 5; i++) begin
      KEY[0] = 1'b0; step(); step();
      KEY[0] = 1'b1; step(); step();
    end
    repeat (D + 4) step();
    checks++;
    if (mode_pending !== 3'(exp_pending))
      begin errors++; $display("FAIL bounce_pending: got %0d expected %0d", mode_pending, exp_pending); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < NM && exp_pending != 0; i++) begin
      press(1, D + 2);
      exp_pending = next_mode(exp_pending, 0);
    end
    checks++;
    if (mode_pending !== 3'd0) begin errors++; $display("FAIL wrap_start: got %0d expected 0", mode_pending); end
    press(1, D + 2); exp_pending = next_mode(exp_pending, 0);
    checks++;
    if (mode_pending !== 3'd3) begin errors++; $display("FAIL wrap_down: got %0d expected 3", mode_pending); end
    press(0, D + 2); exp_pending = next_mode(exp_pending, 1);
    checks++;
    if (mode_pending !== 3'd0) begin errors++; $display("FAIL wrap_up: got %0d expected 0", mode_pending); end
    press(0, D); exp_pending = next_mode(exp_pending, 1);
    checks++;
    if (mode_pending !== 3'd1) begin errors++; $display("FAIL wrap_up_again: got %0d expected 1", mode_pending); end
  endtask

  task automatic test_both_keys();
    KEY = 2'b00;
    repeat (D + 3) step();
    KEY = 2'b11;
    repeat (D + 4) step();
    checks++;
    if (mode_pending !== 3'(exp_pending))
      begin errors++; $display("FAIL both_keys_pending: got %0d expected %0d", mode_pending, exp_pending); end
  endtask

  task automatic test_scan(input int lines, input int pix);
    int pv_cnt;
    int ex, ey;
    pv_cnt = 0;
    test_frame_start();
    for (int l = 0; l < lines; l++) begin
      blank = 1'b1;
      for (int p = 0; p < pix; p++) begin
        step();
        ex = imin(p, W - 1);
        ey = imin(l, H - 1);
        if (pixel_valid === 1'b1) pv_cnt++;
        checks++;
        if ({pixel_valid, x, y} !== {1'b1, 10'(ex), 9'(ey)})
          begin errors++; $display("FAIL scan_pixel: line %0d pix %0d got pv=%b x=%0d y=%0d expected pv=1 x=%0d y=%0d",
                                   l, p, pixel_valid, x, y, ex, ey); end
      end
      blank = 1'b0;
      step();
      ey = imin(l + 1, H - 1);
      checks++;
      if ({pixel_valid, x, y} !== {1'b0, 10'd0, 9'(ey)})
        begin errors++; $display("FAIL scan_hblank: line %0d got pv=%b x=%0d y=%0d expected pv=0 x=0 y=%0d",
                                 l, pixel_valid, x, y, ey); end
      step(); step();
    end
    checks++;
    if (pv_cnt != lines * pix)
      begin errors++; $display("FAIL scan_valid_count: got %0d expected %0d", pv_cnt, lines * pix); end
  endtask

  // Acceptance lands D+2 edges after KEY first reads low: two sync stages, then D low samples.
  task automatic test_collision();
    int old_p, new_p;
    old_p = exp_pending;
    new_p = next_mode(exp_pending, 1);
    KEY[0] = 1'b0;
    repeat (D + 1) step();
    checks++;
    if (mode_pending !== 3'(old_p))
      begin errors++; $display("FAIL collision_early_accept: got %0d expected %0d", mode_pending, old_p); end
    vs = 1'b0;
    step();
    checks++;
    if ({frame_start, mode, mode_pending} !== {1'b1, 3'(old_p), 3'(new_p)})
      begin errors++; $display("FAIL collision_edge: got fs=%b mode=%0d pend=%0d expected fs=1 mode=%0d pend=%0d",
                               frame_start, mode, mode_pending, old_p, new_p); end
    exp_mode = old_p;
    exp_pending = new_p;
    KEY[0] = 1'b1;
    vs = 1'b1;
    repeat (D + 4) step();
    checks++;
    if (mode !== 3'(old_p)) begin errors++; $display("FAIL collision_mode_hold: got %0d expected %0d", mode, old_p); end
    test_frame_start();
    checks++;
    if (mode !== 3'(new_p)) begin errors++; $display("FAIL collision_mode_next: got %0d expected %0d", mode, new_p); end
  endtask

  task automatic test_random_keys();
    int k;
    for (int it = 0; it < 16; it++) begin
      k = $urandom_range(0, 1);
      if ($urandom_range(0, 2) != 0) begin
        press(k, $urandom_range(D, 3 * D));
        exp_pending = next_mode(exp_pending, (k == 0) ? 1 : 0);
      end else begin
        for (int b = 0; b < $urandom_range(2, 5); b++) begin
          KEY[k] = 1'b0;
          repeat ($urandom_range(1, D - 1)) step();
          KEY[k] = 1'b1;
          repeat ($urandom_range(1, 2)) step();
        end
        repeat (D + 4) step();
      end
      checks++;
      if (mode_pending !== 3'(exp_pending))
        begin errors++; $display("FAIL random_pending: iter %0d got %0d expected %0d", it, mode_pending, exp_pending); end
      if ($urandom_range(0, 1) == 1) test_frame_start();
      checks++;
      if ({HEX0, HEX1} !== {exp_hex0(), exp_hex1()})
        begin errors++; $display("FAIL random_hex: iter %0d got %h/%h expected %h/%h", it, HEX0, HEX1, exp_hex0(), exp_hex1()); end
    end
  endtask

  task automatic test_reset_midline();
    test_frame_start();
    blank = 1'b1;
    repeat (6) step();
    checks++;
    if (x !== 10'd5) begin errors++; $display("FAIL midline_x: got %0d expected 5", x); end
    reset = 1'b1;
    step();
    exp_mode = 0;
    exp_pending = 0;
    checks++;
    if ({mode, mode_pending, x, y, pixel_valid, frame_start, HEX0, HEX1} !== {27'd0, 7'h7F, 7'h7F})
      begin errors++; $display("FAIL midline_reset: got mode=%0d pend=%0d x=%0d y=%0d pv=%b fs=%b hex=%h/%h expected zeros, hex 7f/7f",
                               mode, mode_pending, x, y, pixel_valid, frame_start, HEX0, HEX1); end
    reset = 1'b0;
    for (int l = 0; l < 3; l++) begin
      for (int c = 0; c < 11; c++) begin
        blank = (c < 8);
        step();
        checks++;
        if (pixel_valid !== 1'b0)
          begin errors++; $display("FAIL midline_no_valid: line %0d cycle %0d got pv=%b expected 0", l, c, pixel_valid); end
      end
    end
    blank = 1'b0;
    test_frame_start();
    blank = 1'b1;
    step();
    checks++;
    if ({pixel_valid, x, y} !== {1'b1, 10'd0, 9'd0})
      begin errors++; $display("FAIL midline_resume: got pv=%b x=%0d y=%0d expected pv=1 x=0 y=0", pixel_valid, x, y); end
    blank = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_wrap();
    test_both_keys();
    test_scan(4, 8);
    test_scan(6, 10);
    test_collision();
    test_random_keys();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
